pokey_audio_divider: RTL



---
 rtl/pokey_pkg.sv | 33 +++
 rtl/pokey_audio_divider_if.sv | 16 +
 rtl/pokey_chan_counter.sv | 106 ++++++++++
 rtl/pokey_audio_divider.sv | 96 +++++++++
 4 files changed

// File: rtl/pokey_pkg.sv
// pokey_pkg: shared constants for the POKEY audio divider.
// Holds register addresses, AUDCTL bit positions, counter widths and the
// fast-mode reload offsets used by pokey_audio_divider and pokey_chan_counter.
package pokey_pkg;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned AUDF_W  = 8;
  localparam int unsigned CNT_W   = 9;
  localparam int unsigned JCNT_W  = 17;
  localparam int unsigned NUM_CH  = 4;

  // Writable register addresses
  typedef enum logic [ADDR_W-1:0] {
    ADDR_AUDF1  = 4'd0,
    ADDR_AUDF2  = 4'd2,
    ADDR_AUDF3  = 4'd4,
    ADDR_AUDF4  = 4'd6,
    ADDR_AUDCTL = 4'd8,
    ADDR_STIMER = 4'd9
  } reg_addr_e;

  // AUDCTL bit indices
  localparam int unsigned AUDCTL_SEL15   = 0;
  localparam int unsigned AUDCTL_JOIN34  = 3;
  localparam int unsigned AUDCTL_JOIN12  = 4;
  localparam int unsigned AUDCTL_CH3FAST = 5;
  localparam int unsigned AUDCTL_CH1FAST = 6;

  // Extra reload counts in fast mode: absorb the machine-cycle pipeline delay
  localparam int unsigned FAST_OFS_SINGLE = 3;
  localparam int unsigned FAST_OFS_JOIN   = 6;

endpackage

// File: rtl/pokey_audio_divider_if.sv
// pokey_audio_divider_if: register write bus for the audio divider.
//   wrEn   - write strobe
//   addr   - register address
//   wrData - write data
// master drives the bus, slave (the divider) receives it.
interface pokey_audio_divider_if;
  import pokey_pkg::*;

  logic              wrEn;
  logic [ADDR_W-1:0] addr;
  logic [AUDF_W-1:0] wrData;

  modport master (output wrEn, addr, wrData);
  modport slave  (input  wrEn, addr, wrData);

endinterface

// File: rtl/pokey_chan_counter.sv
// pokey_chan_counter: down-counter pair for two audio channels (1+2 or 3+4).
// Runs as two 9-bit counters, or as one 17-bit counter when joined.
// Ports:
//   clk, resetN       - clock, synchronous active-low reset
//   step_fast         - machine-cycle step (enn)
//   step_base         - base-tick step (enn & baseTick)
//   join_en           - pair joined into one 16-bit divider
//   fast_en           - low channel (and joined pair) clocked from step_fast
//   audf_lo, audf_hi  - AUDF values for the low/high channel
//   stimer            - load all counters with their reload value
//                       (present only with POKEY_STIMER_EN defined)
//   tick_lo, tick_hi  - registered one-clk underflow pulses
module pokey_chan_counter
  import pokey_pkg::*;
(
  input  logic              clk,
  input  logic              resetN,
  input  logic              step_fast,
  input  logic              step_base,
  input  logic              join_en,
  input  logic              fast_en,
  input  logic [AUDF_W-1:0] audf_lo,
  input  logic [AUDF_W-1:0] audf_hi,
`ifdef POKEY_STIMER_EN
  input  logic              stimer,
`endif
  output logic              tick_lo,
  output logic              tick_hi
);

  logic [CNT_W-1:0]  cnt_lo;
  logic [CNT_W-1:0]  cnt_hi;
  logic [CNT_W-1:0]  rel_lo;
  logic [CNT_W-1:0]  rel_hi;
  logic [JCNT_W-1:0] cnt_j;
  logic [JCNT_W-1:0] rel_j;
  logic              step_lo;
  logic              step_hi;
  logic              load_all;

`ifdef POKEY_STIMER_EN
  assign load_all = stimer;
`else
  assign load_all = 1'b0;
`endif

  // Step selection and reload values; joined view is {hi, lo[7:0]}
  always_comb begin
    step_lo = fast_en ? step_fast : step_base;
    step_hi = join_en ? step_lo : step_base;
    rel_lo  = CNT_W'(audf_lo) + (fast_en ? CNT_W'(FAST_OFS_SINGLE) : CNT_W'(0));
    rel_hi  = CNT_W'(audf_hi);
    rel_j   = JCNT_W'({audf_hi, audf_lo}) + (fast_en ? JCNT_W'(FAST_OFS_JOIN) : JCNT_W'(0));
    cnt_j   = {cnt_hi, cnt_lo[AUDF_W-1:0]};
  end

  // Counter update; load_all overrides any underflow that clk
  always_ff @(posedge clk) begin
    if (!resetN) begin
      cnt_lo  <= '0;
      cnt_hi  <= '0;
      tick_lo <= 1'b0;
      tick_hi <= 1'b0;
    end else begin
      tick_lo <= 1'b0;
      tick_hi <= 1'b0;
      if (load_all) begin
        if (join_en) begin
          cnt_hi <= rel_j[JCNT_W-1:AUDF_W];
          cnt_lo <= {1'b0, rel_j[AUDF_W-1:0]};
        end else begin
          cnt_lo <= rel_lo;
          cnt_hi <= rel_hi;
        end
      end else if (join_en) begin
        if (step_lo) begin
          if (cnt_j == JCNT_W'(0)) begin
            cnt_hi  <= rel_j[JCNT_W-1:AUDF_W];
            cnt_lo  <= {1'b0, rel_j[AUDF_W-1:0]};
            tick_hi <= 1'b1;
          end else begin
            {cnt_hi, cnt_lo[AUDF_W-1:0]} <= cnt_j - JCNT_W'(1);
          end
        end
      end else begin
        if (step_lo) begin
          if (cnt_lo == CNT_W'(0)) begin
            cnt_lo  <= rel_lo;
            tick_lo <= 1'b1;
          end else begin
            cnt_lo <= cnt_lo - CNT_W'(1);
          end
        end
        if (step_hi) begin
          if (cnt_hi == CNT_W'(0)) begin
            cnt_hi  <= rel_hi;
            tick_hi <= 1'b1;
          end else begin
            cnt_hi <= cnt_hi - CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/pokey_audio_divider.sv
// pokey_audio_divider: POKEY audio frequency divider scheduler.
// Holds AUDF1-AUDF4 and AUDCTL, runs two channel-pair counters and emits
// per-channel underflow pulses.
// Ports:
//   clk, resetN - clock, synchronous active-low reset
//   enn         - 1.79 MHz machine-cycle enable (one clk wide)
//   baseTick    - 64/15 kHz base tick (only high together with enn)
//   bus         - register write bus (wrEn, addr, wrData)
//   sel15Khz    - AUDCTL[0], registered
//   chanTick    - per-channel underflow pulse, registered, one clk wide
// Build option: POKEY_STIMER_EN enables the STIMER write at address 9.
module pokey_audio_divider
  import pokey_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 enn,
  input  logic                 baseTick,
  pokey_audio_divider_if.slave bus,
  output logic                 sel15Khz,
  output logic [NUM_CH-1:0]    chanTick
);

  logic [AUDF_W-1:0] audf1;
  logic [AUDF_W-1:0] audf2;
  logic [AUDF_W-1:0] audf3;
  logic [AUDF_W-1:0] audf4;
  logic [AUDF_W-1:0] audctl;
  logic              step_base;
  logic              audctl_unused_bits;

  // Register file; writes are independent of enn
  always_ff @(posedge clk) begin
    if (!resetN) begin
      audf1  <= '0;
      audf2  <= '0;
      audf3  <= '0;
      audf4  <= '0;
      audctl <= '0;
    end else if (bus.wrEn) begin
      case (bus.addr)
        ADDR_AUDF1:  audf1  <= bus.wrData;
        ADDR_AUDF2:  audf2  <= bus.wrData;
        ADDR_AUDF3:  audf3  <= bus.wrData;
        ADDR_AUDF4:  audf4  <= bus.wrData;
        ADDR_AUDCTL: audctl <= bus.wrData;
        default:     ;
      endcase
    end
  end

  assign step_base          = enn & baseTick;
  assign sel15Khz           = audctl[AUDCTL_SEL15];
  // Bits 1, 2 and 7 are stored for readback compatibility but drive nothing
  assign audctl_unused_bits = ^{audctl[7], audctl[2:1]};

`ifdef POKEY_STIMER_EN
  logic stimer;
  assign stimer = bus.wrEn && (bus.addr == ADDR_STIMER);
`endif

  // Channels 1+2
  pokey_chan_counter u_pair12 (
    .clk       (clk),
    .resetN    (resetN),
    .step_fast (enn),
    .step_base (step_base),
    .join_en   (audctl[AUDCTL_JOIN12]),
    .fast_en   (audctl[AUDCTL_CH1FAST]),
    .audf_lo   (audf1),
    .audf_hi   (audf2),
`ifdef POKEY_STIMER_EN
    .stimer    (stimer),
`endif
    .tick_lo   (chanTick[0]),
    .tick_hi   (chanTick[1])
  );

  // Channels 3+4
  pokey_chan_counter u_pair34 (
    .clk       (clk),
    .resetN    (resetN),
    .step_fast (enn),
    .step_base (step_base),
    .join_en   (audctl[AUDCTL_JOIN34]),
    .fast_en   (audctl[AUDCTL_CH3FAST]),
    .audf_lo   (audf3),
    .audf_hi   (audf4),
`ifdef POKEY_STIMER_EN
    .stimer    (stimer),
`endif
    .tick_lo   (chanTick[2]),
    .tick_hi   (chanTick[3])
  );

endmodule
